btn_conditioner: RTL and testbench

Conditions the raw push-button inputs (BtnU, BtnL, BtnR and similar) before they reach the game logic in the VGA project. Each button passes through three stages:
- a two-flop synchronizer;
- a per-button debounce state machine;
- an edge/auto-repeat generator.

The block produces a clean debounced level and single-cycle press pulses, so the game logic responds to one start event per physical press and gets a steady paddle-move cadence while left/right are held. It sits between the board pins and the pixel/game logic, in the 100 MHz clock domain.

---
 rtl/btn_conditioner.sv | 102 ++++++++++
 tb/tb_btn_conditioner.sv | 93 +++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize, debounce and press/release/auto-repeat pulse generation for push buttons
module btn_conditioner #(
  parameter int NUM_BTNS        = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 30_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_repeat,
  output logic [NUM_BTNS-1:0] btn_release
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX) + 1;
  localparam logic [DW-1:0] DEB_TERM = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [RW-1:0] REP_DLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_PER = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] REP_SAT = '1;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  logic [NUM_BTNS-1:0] s1, s2;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    state_t state;
    logic [DW-1:0] cnt;
    logic [RW-1:0] rcnt, rnext;
    logic first, rhit, lvl, prs, rpt, rls;
    always_comb begin
      rnext = rcnt == REP_SAT ? rcnt : rcnt + RW'(1);
      rhit = REPEAT_DELAY != 0 && rnext == (first ? REP_DLY : REP_PER);
    end
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        state <= IDLE;
        cnt <= '0;
        rcnt <= '0;
        first <= 1'b0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rpt <= 1'b0;
        rls <= 1'b0;
      end else begin
        prs <= 1'b0;
        rpt <= 1'b0;
        rls <= 1'b0;
        if (state == HELD || state == RELEASE_WAIT) begin
          rcnt <= rhit ? '0 : rnext;
          rpt <= rhit;
          if (rhit) first <= 1'b0;
        end
        case (state)
          IDLE:
            if (s2[i]) begin
              state <= PRESS_WAIT;
              cnt <= '0;
            end
          PRESS_WAIT:
            if (!s2[i]) begin
              state <= IDLE;
              cnt <= '0;
            end else if (cnt == DEB_TERM) begin
              state <= HELD;
              lvl <= 1'b1;
              prs <= 1'b1;
              rpt <= 1'b1;
              rcnt <= '0;
              first <= 1'b1;
            end else cnt <= cnt + DW'(1);
          HELD:
            if (!s2[i]) begin
              state <= RELEASE_WAIT;
              cnt <= '0;
            end
          RELEASE_WAIT:
            if (s2[i]) state <= HELD;
            else if (cnt == DEB_TERM) begin
              state <= IDLE;
              lvl <= 1'b0;
              rls <= 1'b1;
              rpt <= 1'b0;
            end else cnt <= cnt + DW'(1);
          default: state <= IDLE;
        endcase
      end
    end
    assign btn_level[i] = lvl;
    assign btn_press[i] = prs;
    assign btn_repeat[i] = rpt;
    assign btn_release[i] = rls;
  end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed self-checking bench for btn_conditioner
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rn_a, rn_b;
  logic [2:0] raw_a, raw_b;
  logic [2:0] lvl_a, prs_a, rpt_a, rls_a;
  logic [2:0] lvl_b, prs_b, rpt_b, rls_b;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  btn_conditioner #(.NUM_BTNS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut_a (
    .clk(clk), .reset_n(rn_a), .btn_raw(raw_a),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_repeat(rpt_a), .btn_release(rls_a)
  );
  btn_conditioner #(.NUM_BTNS(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)) dut_b (
    .clk(clk), .reset_n(rn_b), .btn_raw(raw_b),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_repeat(rpt_b), .btn_release(rls_b)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic check_a(input string tag, input int n, input logic [2:0] l, input logic [2:0] p,
                         input logic [2:0] r, input logic [2:0] x);
    chk($sformatf("%s e%0d level", tag, n), lvl_a, l);
    chk($sformatf("%s e%0d press", tag, n), prs_a, p);
    chk($sformatf("%s e%0d repeat", tag, n), rpt_a, r);
    chk($sformatf("%s e%0d release", tag, n), rls_a, x);
  endtask
  initial begin
    int np;
    rn_a = 1'b0;
    rn_b = 1'b0;
    raw_a = 3'b111;
    raw_b = 3'b000;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check_a("reset", n, 3'b000, 3'b000, 3'b000, 3'b000);
    end
    rn_a = 1'b1;
    rn_b = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      raw_a = n < 8 ? 3'b111 : 3'b000;
      tick();
      check_a("post_reset", n, {3{n >= 6 && n < 13}}, {3{n == 6}}, {3{n == 6}}, {3{n == 13}});
    end
    for (int n = 1; n <= 30; n++) begin
      raw_a = n < 20 ? 3'b001 : 3'b000;
      tick();
      check_a("clean", n, {2'b00, n >= 6 && n < 25}, {2'b00, n == 6},
              {2'b00, n == 6 || (n >= 16 && n < 25 && (n - 16) % 3 == 0)}, {2'b00, n == 25});
    end
    np = 0;
    for (int n = 1; n <= 22; n++) begin
      raw_a = {1'b0, !(n == 3 || n == 7 || n >= 15), 1'b0};
      tick();
      np += int'(prs_a[1]);
      check_a("bounce", n, {1'b0, n >= 13 && n < 20, 1'b0}, {1'b0, n == 13, 1'b0},
              {1'b0, n == 13, 1'b0}, {1'b0, n == 20, 1'b0});
    end
    chk("bounce press count", 3'(np), 3'd1);
    for (int n = 1; n <= 40; n++) begin
      raw_a = {n <= 16 || (n >= 19 && n <= 30), 2'b00};
      tick();
      check_a("glitch", n, {n >= 6 && n < 36, 2'b00}, {n == 6, 2'b00},
              {n == 6 || (n >= 16 && n <= 34 && (n - 16) % 3 == 0), 2'b00}, {n == 36, 2'b00});
    end
    for (int n = 1; n <= 45; n++) begin
      raw_b = 3'b111;
      tick();
      chk($sformatf("simul e%0d level", n), lvl_b, {3{n >= 6}});
      chk($sformatf("simul e%0d press", n), prs_b, {3{n == 6}});
      chk($sformatf("simul e%0d repeat", n), rpt_b, {3{n == 6}});
      chk($sformatf("simul e%0d release", n), rls_b, 3'b000);
    end
    for (int n = 1; n <= 15; n++) begin
      raw_a = 3'b001;
      rn_a = n != 8;
      tick();
      check_a("midreset", n, {2'b00, (n >= 6 && n < 8) || n >= 14}, {2'b00, n == 6 || n == 14},
              {2'b00, n == 6 || n == 14}, 3'b000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
